// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset main control FSM:
// state encodings, opcode constants, ALUOp codes, datapath select codes
// and the opcode-class record produced by mc_opcode_class.
package mc_ctrl_pkg;

  // 4-bit state encodings (also visible on state_o for debug)
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR = 4'd3;
  localparam logic [3:0] ST_MEM_RD   = 4'd4;
  localparam logic [3:0] ST_MEM_WB   = 4'd5;
  localparam logic [3:0] ST_MEM_WR   = 4'd6;
  localparam logic [3:0] ST_EXEC_R   = 4'd7;
  localparam logic [3:0] ST_R_WB     = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
  localparam logic [3:0] ST_JUMP     = 4'd10;
  localparam logic [3:0] ST_EXEC_I   = 4'd11;
  localparam logic [3:0] ST_I_WB     = 4'd12;
  localparam logic [3:0] ST_HALT     = 4'd13;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_DECODE   = ST_DECODE,
    S_MEM_ADDR = ST_MEM_ADDR,
    S_MEM_RD   = ST_MEM_RD,
    S_MEM_WB   = ST_MEM_WB,
    S_MEM_WR   = ST_MEM_WR,
    S_EXEC_R   = ST_EXEC_R,
    S_R_WB     = ST_R_WB,
    S_BRANCH   = ST_BRANCH,
    S_JUMP     = ST_JUMP,
    S_EXEC_I   = ST_EXEC_I,
    S_I_WB     = ST_I_WB,
    S_HALT     = ST_HALT
  } state_t;

  // IR[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_LUI   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       is_mem;      // LW or SW
    logic       is_lw;
    logic       is_r;
    logic       is_beq;
    logic       is_j;
    logic       is_imm;      // ADDI/ADDIU/LUI/ORI
    logic [3:0] imm_alu_op;
    logic       imm_zext;
    logic       is_illegal;  // none of the above
  } op_class_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier for the main control FSM.
// Ports: opcode (IR[31:26]) in; cls (op_class_t: instruction class flags,
// immediate-form ALUOp and extension mode, illegal flag) out.
module mc_opcode_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    cls.imm_alu_op = ALU_ADD;
    case (opcode)
      OP_LW: begin
        cls.is_mem = 1'b1;
        cls.is_lw  = 1'b1;
      end
      OP_SW:    cls.is_mem = 1'b1;
      OP_RTYPE: cls.is_r   = 1'b1;
      OP_BEQ:   cls.is_beq = 1'b1;
      OP_J:     cls.is_j   = 1'b1;
      OP_ADDI, OP_ADDIU: cls.is_imm = 1'b1;
      OP_LUI: begin
        cls.is_imm     = 1'b1;
        cls.imm_alu_op = ALU_LUI;
      end
      OP_ORI: begin
        cls.is_imm     = 1'b1;
        cls.imm_alu_op = ALU_OR;
        cls.imm_zext   = 1'b1;
      end
      default: cls.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM (fetch/decode/execute/memory/writeback) for
// the MIPS-subset datapath, with a memory wait-cycle watchdog.
// Ports: clk, rst_n, opcode, zero, mem_ready in; datapath strobes/selects
// (pc_write, pc_source, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
// alu_src_b, imm_zext, alu_op, reg_write, reg_dst, mem_to_reg), state_o,
// mem_timeout, illegal out.
// Optional: define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in HALT
// (sticky illegal flag); otherwise unknown opcodes execute as a NOP.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state_o,
  output logic       mem_timeout,
  output logic       illegal
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

  state_t            state, state_nxt;
  op_class_t         cls;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              waiting;

  mc_opcode_class u_cls (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A memory wait cycle is a cycle in a memory-access state without ready.
  // Every exit from those states requires mem_ready, so clearing on ready
  // also covers clearing on leaving the state.
  assign waiting  = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                    && !mem_ready;
  assign wait_nxt = !waiting      ? '0 :
                    (&wait_cnt)   ? wait_cnt :
                                    wait_cnt + WAIT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      // Flag is raised on the same edge the counter reaches the limit.
      if ((WAIT_LIMIT != 0) && (wait_nxt == LIMIT)) mem_timeout <= 1'b1;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    illegal <= 1'b0;
    else if ((state == S_DECODE) && cls.is_illegal) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  assign state_o = state;

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    imm_zext   = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 are captured only on the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut
        alu_src_b = SRCB_IMM_SH2;
        if      (cls.is_mem) state_nxt = S_MEM_ADDR;
        else if (cls.is_r)   state_nxt = S_EXEC_R;
        else if (cls.is_beq) state_nxt = S_BRANCH;
        else if (cls.is_j)   state_nxt = S_JUMP;
        else if (cls.is_imm) state_nxt = S_EXEC_I;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        else if (cls.is_illegal) state_nxt = S_HALT;
`else
        else if (cls.is_illegal) state_nxt = S_FETCH;
`endif
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = cls.is_lw ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
        state_nxt = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = zero;
        state_nxt = S_FETCH;
      end

      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = cls.imm_alu_op;
        imm_zext  = cls.imm_zext;
        state_nxt = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      // Trapped: all strobes stay low until reset
      S_HALT: state_nxt = S_HALT;
`endif

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } out_t;

  typedef struct {
    logic [5:0] opc;
    logic       rdy;
    logic       zr;
    logic [3:0] st;
    logic [3:0] aop;
    logic       pw;
    logic       rw;
    logic       mr;
    logic [1:0] sb;
    logic       zx;
  } vec_t;

  typedef struct packed {
    logic [3:0] st;
    out_t       o;
    logic       mem;      // memory step: held while mem_ready is low
    logic       rdy_pw;   // pc_write/ir_write follow mem_ready
    logic       zero_pw;  // pc_write follows zero
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  // DUT a: watchdog limit 3; DUT b: default (watchdog disabled)
  logic       pc_write_a, ir_write_a, mem_read_a, mem_write_a, i_or_d_a, alu_src_a_a;
  logic       imm_zext_a, reg_write_a, reg_dst_a, mem_to_reg_a, mem_timeout_a, illegal_a;
  logic [1:0] pc_source_a, alu_src_b_a;
  logic [3:0] alu_op_a, state_a;
  logic       pc_write_b, ir_write_b, mem_read_b, mem_write_b, i_or_d_b, alu_src_a_b;
  logic       imm_zext_b, reg_write_b, reg_dst_b, mem_to_reg_b, mem_timeout_b, illegal_b;
  logic [1:0] pc_source_b, alu_src_b_b;
  logic [3:0] alu_op_b, state_b;

  mc_ctrl_fsm #(.WAIT_W(8), .WAIT_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .pc_source(pc_source_a), .ir_write(ir_write_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .i_or_d(i_or_d_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .imm_zext(imm_zext_a),
    .alu_op(alu_op_a), .reg_write(reg_write_a), .reg_dst(reg_dst_a),
    .mem_to_reg(mem_to_reg_a), .state_o(state_a), .mem_timeout(mem_timeout_a),
    .illegal(illegal_a)
  );

  mc_ctrl_fsm dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .pc_source(pc_source_b), .ir_write(ir_write_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .i_or_d(i_or_d_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .imm_zext(imm_zext_b),
    .alu_op(alu_op_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b),
    .mem_to_reg(mem_to_reg_b), .state_o(state_b), .mem_timeout(mem_timeout_b),
    .illegal(illegal_b)
  );

  out_t o_a, o_b;
  assign o_a = {pc_write_a, pc_source_a, ir_write_a, mem_read_a, mem_write_a, i_or_d_a,
                alu_src_a_a, alu_src_b_a, imm_zext_a, alu_op_a, reg_write_a, reg_dst_a,
                mem_to_reg_a};
  assign o_b = {pc_write_b, pc_source_b, ir_write_b, mem_read_b, mem_write_b, i_or_d_b,
                alu_src_a_b, alu_src_b_b, imm_zext_b, alu_op_b, reg_write_b, reg_dst_b,
                mem_to_reg_b};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Leaves the bench at the start of the first FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", state_a, ST_IDLE);
    chk("rst_timeout", mem_timeout_a, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_state", state_a, ST_IDLE);
    chk("idle_outs", o_a, 0);
    chk("idle_illegal", illegal_a, 0);
    @(negedge clk);
  endtask

  function automatic vec_t v(input logic [5:0] opc, input logic rdy, input logic zr,
                             input logic [3:0] st, input logic [3:0] aop, input logic pw,
                             input logic rw, input logic mr, input logic [1:0] sb,
                             input logic zx);
    vec_t r;
    r.opc = opc; r.rdy = rdy; r.zr = zr; r.st = st; r.aop = aop;
    r.pw = pw; r.rw = rw; r.mr = mr; r.sb = sb; r.zx = zx;
    return r;
  endfunction

  function automatic step_t mk(input logic [3:0] st, input out_t o, input logic mem,
                               input logic rdy_pw, input logic zero_pw);
    step_t s;
    s.st = st; s.o = o; s.mem = mem; s.rdy_pw = rdy_pw; s.zero_pw = zero_pw;
    return s;
  endfunction

  // Reference model: an instruction is a list of steps; memory steps repeat
  // while mem_ready is low.
  step_t q[$];

  task automatic push_instr(input logic [5:0] opc);
    out_t o;
    o = '0; o.mem_read = 1'b1; o.alu_src_b = SRCB_FOUR;
    q.push_back(mk(ST_FETCH, o, 1'b1, 1'b1, 1'b0));
    o = '0; o.alu_src_b = SRCB_IMM_SH2;
    q.push_back(mk(ST_DECODE, o, 1'b0, 1'b0, 1'b0));
    case (opc)
      OP_LW, OP_SW: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = SRCB_IMM;
        q.push_back(mk(ST_MEM_ADDR, o, 1'b0, 1'b0, 1'b0));
        if (opc == OP_LW) begin
          o = '0; o.mem_read = 1'b1; o.i_or_d = 1'b1;
          q.push_back(mk(ST_MEM_RD, o, 1'b1, 1'b0, 1'b0));
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          q.push_back(mk(ST_MEM_WB, o, 1'b0, 1'b0, 1'b0));
        end else begin
          o = '0; o.mem_write = 1'b1; o.i_or_d = 1'b1;
          q.push_back(mk(ST_MEM_WR, o, 1'b1, 1'b0, 1'b0));
        end
      end
      OP_RTYPE: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = ALU_RTYPE;
        q.push_back(mk(ST_EXEC_R, o, 1'b0, 1'b0, 1'b0));
        o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1;
        q.push_back(mk(ST_R_WB, o, 1'b0, 1'b0, 1'b0));
      end
      OP_BEQ: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = ALU_SUB; o.pc_source = PCSRC_ALUOUT;
        q.push_back(mk(ST_BRANCH, o, 1'b0, 1'b0, 1'b1));
      end
      OP_J: begin
        o = '0; o.pc_source = PCSRC_JUMP; o.pc_write = 1'b1;
        q.push_back(mk(ST_JUMP, o, 1'b0, 1'b0, 1'b0));
      end
      OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = SRCB_IMM;
        o.alu_op = (opc == OP_LUI) ? ALU_LUI : (opc == OP_ORI) ? ALU_OR : ALU_ADD;
        o.imm_zext = (opc == OP_ORI);
        q.push_back(mk(ST_EXEC_I, o, 1'b0, 1'b0, 1'b0));
        o = '0; o.reg_write = 1'b1;
        q.push_back(mk(ST_I_WB, o, 1'b0, 1'b0, 1'b0));
      end
      default: ;
    endcase
  endtask

  vec_t       tbl[$];
  logic [5:0] ops[$];

  initial begin
    step_t s;
    out_t  e;
    logic  rdy, zr, model_to;
    int    run, err0;
    logic [5:0] cur_opc;

    tbl = '{
      v(OP_RTYPE, 1, 0, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0),
      v(OP_RTYPE, 1, 0, ST_DECODE,   ALU_ADD,   0, 0, 0, SRCB_IMM_SH2, 0),
      v(OP_RTYPE, 1, 0, ST_EXEC_R,   ALU_RTYPE, 0, 0, 0, SRCB_B,       0),
      v(OP_RTYPE, 1, 0, ST_R_WB,     ALU_ADD,   0, 1, 0, SRCB_B,       0),
      v(OP_LW,    1, 0, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0),
      v(OP_LW,    1, 0, ST_DECODE,   ALU_ADD,   0, 0, 0, SRCB_IMM_SH2, 0),
      v(OP_LW,    1, 0, ST_MEM_ADDR, ALU_ADD,   0, 0, 0, SRCB_IMM,     0),
      v(OP_LW,    0, 0, ST_MEM_RD,   ALU_ADD,   0, 0, 1, SRCB_B,       0),
      v(OP_LW,    0, 0, ST_MEM_RD,   ALU_ADD,   0, 0, 1, SRCB_B,       0),
      v(OP_LW,    1, 0, ST_MEM_RD,   ALU_ADD,   0, 0, 1, SRCB_B,       0),
      v(OP_LW,    1, 0, ST_MEM_WB,   ALU_ADD,   0, 1, 0, SRCB_B,       0),
      v(OP_BEQ,   1, 1, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0),
      v(OP_BEQ,   1, 1, ST_DECODE,   ALU_ADD,   0, 0, 0, SRCB_IMM_SH2, 0),
      v(OP_BEQ,   1, 1, ST_BRANCH,   ALU_SUB,   1, 0, 0, SRCB_B,       0),
      v(OP_BEQ,   1, 0, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0),
      v(OP_BEQ,   1, 0, ST_DECODE,   ALU_ADD,   0, 0, 0, SRCB_IMM_SH2, 0),
      v(OP_BEQ,   1, 0, ST_BRANCH,   ALU_SUB,   0, 0, 0, SRCB_B,       0),
      v(OP_ORI,   1, 0, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0),
      v(OP_ORI,   1, 0, ST_DECODE,   ALU_ADD,   0, 0, 0, SRCB_IMM_SH2, 0),
      v(OP_ORI,   1, 0, ST_EXEC_I,   ALU_OR,    0, 0, 0, SRCB_IMM,     1),
      v(OP_ORI,   1, 0, ST_I_WB,     ALU_ADD,   0, 1, 0, SRCB_B,       0),
      v(OP_LUI,   1, 0, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0),
      v(OP_LUI,   1, 0, ST_DECODE,   ALU_ADD,   0, 0, 0, SRCB_IMM_SH2, 0),
      v(OP_LUI,   1, 0, ST_EXEC_I,   ALU_LUI,   0, 0, 0, SRCB_IMM,     0),
      v(OP_LUI,   1, 0, ST_I_WB,     ALU_ADD,   0, 1, 0, SRCB_B,       0),
      v(OP_J,     0, 0, ST_FETCH,    ALU_ADD,   0, 0, 1, SRCB_FOUR,    0),
      v(OP_J,     1, 0, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0),
      v(OP_J,     1, 0, ST_DECODE,   ALU_ADD,   0, 0, 0, SRCB_IMM_SH2, 0),
      v(OP_J,     1, 0, ST_JUMP,     ALU_ADD,   1, 0, 0, SRCB_B,       0),
      v(OP_RTYPE, 1, 0, ST_FETCH,    ALU_ADD,   1, 0, 1, SRCB_FOUR,    0)
    };

    // ---- directed table ----
    do_reset();
    foreach (tbl[i]) begin
      opcode = tbl[i].opc; mem_ready = tbl[i].rdy; zero = tbl[i].zr;
      #1;
      chk($sformatf("tbl%0d_state", i), state_a, tbl[i].st);
      chk($sformatf("tbl%0d_alu_op", i), alu_op_a, tbl[i].aop);
      chk($sformatf("tbl%0d_pc_write", i), pc_write_a, tbl[i].pw);
      chk($sformatf("tbl%0d_reg_write", i), reg_write_a, tbl[i].rw);
      chk($sformatf("tbl%0d_mem_read", i), mem_read_a, tbl[i].mr);
      chk($sformatf("tbl%0d_alu_src_b", i), alu_src_b_a, tbl[i].sb);
      chk($sformatf("tbl%0d_imm_zext", i), imm_zext_a, tbl[i].zx);
      @(negedge clk);
    end

    // ---- watchdog: limit 3, fetch stalled ----
    do_reset();
    opcode = OP_RTYPE; mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("wdog_wait%0d", k), mem_timeout_a, (k >= 3));
      chk($sformatf("wdog_state%0d", k), state_a, ST_FETCH);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    chk("wdog_sticky_ready", mem_timeout_a, 1);
    @(negedge clk);
    #1;
    chk("wdog_sticky_decode", mem_timeout_a, 1);
    chk("wdog_disabled", mem_timeout_b, 0);

    // ---- reset pulse in MEM_WR ----
    do_reset();
    opcode = OP_SW; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("sw_state", state_a, ST_MEM_WR);
    chk("sw_mem_write", mem_write_a, 1);
    @(negedge clk);
    #1;
    chk("sw_wait_state", state_a, ST_MEM_WR);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", o_a, 0);
    chk("abort_state", state_a, ST_IDLE);

    // ---- unknown opcode ----
    do_reset();
    opcode = 6'b111111; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      chk($sformatf("ill_state%0d", k), state_a, ST_HALT);
      chk($sformatf("ill_flag%0d", k), illegal_a, 1);
      chk($sformatf("ill_outs%0d", k), o_a, 0);
      chk($sformatf("ill_flag_b%0d", k), illegal_b, 1);
`else
      chk($sformatf("ill_flag%0d", k), illegal_a, 0);
      chk($sformatf("ill_flag_b%0d", k), illegal_b, 0);
`endif
      @(negedge clk);
    end
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    // NOP: sequence was FETCH, DECODE, FETCH, DECODE, FETCH
    #1;
    chk("ill_nop_state", state_a, ST_DECODE);
`endif

    // ---- randomized run against the step-list model ----
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI};
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    ops.push_back(6'b111111);
    ops.push_back(6'b000101);
`endif
    do_reset();
    q.delete();
    model_to = 1'b0;
    run = 0;
    cur_opc = OP_RTYPE;
    err0 = errors;
    for (int c = 0; c < 3000; c++) begin
      if (q.size() == 0) begin
        cur_opc = ops[$urandom_range(0, ops.size() - 1)];
        push_instr(cur_opc);
      end
      s = q[0];
      rdy = s.mem ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      zr = 1'($urandom_range(0, 1));
      opcode = cur_opc; mem_ready = rdy; zero = zr;
      #1;
      e = s.o;
      if (s.rdy_pw) begin e.pc_write = rdy; e.ir_write = rdy; end
      if (s.zero_pw) e.pc_write = zr;
      chk("rnd_state", state_a, s.st);
      chk("rnd_outs", o_a, e);
      chk("rnd_timeout", mem_timeout_a, model_to);
      chk("rnd_state_b", state_b, s.st);
      chk("rnd_outs_b", o_b, e);
      chk("rnd_timeout_b", mem_timeout_b, 0);
      chk("rnd_illegal", {illegal_a, illegal_b}, 0);
      if (s.mem && !rdy) begin
        run++;
        if (run == 3) model_to = 1'b1;
      end else begin
        run = 0;
        void'(q.pop_front());
      end
      @(negedge clk);
      if (errors > err0 + 10) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
